// File: rtl/simon_press_checker_if.sv
// Controller-facing bus of the Simon press checker.
// master: the game controller (issues start/round_len, serves exp_color).
// slave : the press checker (walks step_idx, reports press/round events).
interface simon_press_checker_if #(
    parameter int IDX_W = 5
);
    logic             start;
    logic [IDX_W-1:0] round_len;
    logic [1:0]       exp_color;
    logic [IDX_W-1:0] step_idx;
    logic             busy;
    logic             press_valid;
    logic [1:0]       press_color;
    logic             round_ok;
    logic             round_fail;
    logic [1:0]       fail_code;

    modport master (
        output start, round_len, exp_color,
        input  step_idx, busy, press_valid, press_color, round_ok, round_fail, fail_code
    );

    modport slave (
        input  start, round_len, exp_color,
        output step_idx, busy, press_valid, press_color, round_ok, round_fail, fail_code
    );
endinterface

// File: rtl/simon_press_checker.sv
// Simon player-input checker: synchronises and debounces four raw colour
// buttons, compares each accepted press with the expected colour from the
// sequence store and reports press / round-pass / round-fail events.
module simon_press_checker #(
    parameter int IDX_W           = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_TICKS   = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           btn_in,
    input  logic                 tick,
    simon_press_checker_if.slave ctl
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, ARMED, HELD} state_t;

    logic [3:0]      sync1_reg, sync2_reg;
    logic [3:0]      cand_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic [3:0]      btn_stable_reg;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] step_reg, step_next;
    logic [IDX_W-1:0] len_reg, len_next;
    logic [TO_W-1:0]  tcnt_reg, tcnt_next;
    logic             press_valid_reg, press_valid_next;
    logic [1:0]       color_reg, color_next;
    logic             round_ok_reg, round_ok_next;
    logic             round_fail_reg, round_fail_next;
    logic [1:0]       fail_reg, fail_next;

    logic [1:0]       pressed_color;
    logic             multi_press;

    // Two-flop synchroniser, one chain per button.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= btn_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // Debouncer: a new vector is adopted only after DEBOUNCE_CYCLES identical
    // consecutive samples that all differ from the current stable vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg       <= 4'b0;
            db_cnt_reg     <= '0;
            btn_stable_reg <= 4'b0;
        end else if (sync2_reg == btn_stable_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == '0 || sync2_reg != cand_reg) begin
            cand_reg   <= sync2_reg;
            db_cnt_reg <= DB_W'(1);
        end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_stable_reg <= sync2_reg;
            db_cnt_reg     <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    // Decode the stable vector into a colour and flag multi-button presses.
    always_comb begin
        pressed_color = 2'd0;
        case (btn_stable_reg)
            4'b0010: pressed_color = 2'd1;
            4'b0100: pressed_color = 2'd2;
            4'b1000: pressed_color = 2'd3;
            default: pressed_color = 2'd0;
        endcase
        multi_press = (btn_stable_reg & (btn_stable_reg - 4'd1)) != 4'd0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            step_reg        <= '0;
            len_reg         <= '0;
            tcnt_reg        <= '0;
            press_valid_reg <= 1'b0;
            color_reg       <= 2'd0;
            round_ok_reg    <= 1'b0;
            round_fail_reg  <= 1'b0;
            fail_reg        <= 2'd0;
        end else begin
            state_reg       <= state_next;
            step_reg        <= step_next;
            len_reg         <= len_next;
            tcnt_reg        <= tcnt_next;
            press_valid_reg <= press_valid_next;
            color_reg       <= color_next;
            round_ok_reg    <= round_ok_next;
            round_fail_reg  <= round_fail_next;
            fail_reg        <= fail_next;
        end
    end

    // Next-state logic; start overrides everything else in the same cycle.
    // In ARMED the stable vector is always 0 on entry, so any non-zero value
    // there is a fresh press event.
    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        len_next         = len_reg;
        tcnt_next        = tcnt_reg;
        press_valid_next = 1'b0;
        color_next       = color_reg;
        round_ok_next    = 1'b0;
        round_fail_next  = 1'b0;
        fail_next        = fail_reg;

        if (ctl.start) begin
            step_next = '0;
            fail_next = 2'b00;
            tcnt_next = '0;
            if (ctl.round_len == '0) begin
                round_ok_next = 1'b1;
                state_next    = IDLE;
            end else begin
                len_next   = ctl.round_len;
                state_next = (btn_stable_reg == 4'b0) ? ARMED : CLEAR;
            end
        end else begin
            case (state_reg)
                IDLE: ;
                CLEAR: begin
                    if (btn_stable_reg == 4'b0) state_next = ARMED;
                end
                ARMED: begin
                    if (btn_stable_reg != 4'b0) begin
                        if (multi_press) begin
                            round_fail_next = 1'b1;
                            fail_next       = 2'b11;
                            state_next      = IDLE;
                        end else if (pressed_color != ctl.exp_color) begin
                            round_fail_next = 1'b1;
                            fail_next       = 2'b01;
                            color_next      = pressed_color;
                            state_next      = IDLE;
                        end else begin
                            press_valid_next = 1'b1;
                            color_next       = pressed_color;
                            state_next       = HELD;
                        end
                    end else if (tick) begin
                        if (tcnt_reg == TO_W'(TIMEOUT_TICKS - 1)) begin
                            round_fail_next = 1'b1;
                            fail_next       = 2'b10;
                            state_next      = IDLE;
                        end else begin
                            tcnt_next = tcnt_reg + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (btn_stable_reg == 4'b0) begin
                        if (step_reg == IDX_W'(len_reg - 1'b1)) begin
                            round_ok_next = 1'b1;
                            state_next    = IDLE;
                        end else begin
                            step_next  = step_reg + 1'b1;
                            tcnt_next  = '0;
                            state_next = ARMED;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign ctl.step_idx    = step_reg;
    assign ctl.busy        = (state_reg != IDLE);
    assign ctl.press_valid = press_valid_reg;
    assign ctl.press_color = color_reg;
    assign ctl.round_ok    = round_ok_reg;
    assign ctl.round_fail  = round_fail_reg;
    assign ctl.fail_code   = fail_reg;
endmodule
